// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse measurement chain.
package pulse_meas_pkg;

  localparam int unsigned W_TIME_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_PUBLISH
  } stats_state_t;

endpackage

// File: rtl/pulse_stats_ring.sv
// Circular buffer of the last DEPTH samples; reports the entry about to be overwritten.
module pulse_stats_ring #(
  parameter int unsigned W_TIME = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [W_TIME-1:0] wr_data,
  output logic [W_TIME-1:0] old_data,
  output logic              full
);
  localparam int unsigned LOG2 = $clog2(DEPTH);
  localparam logic [LOG2:0] FillMax = (LOG2 + 1)'(DEPTH);

  logic [W_TIME-1:0] mem_q [DEPTH];
  logic [LOG2-1:0]   wr_ptr_q;
  logic [LOG2:0]     fill_q;

  assign full     = (fill_q == FillMax);
  // Nothing is evicted until the window has filled once.
  assign old_data = full ? mem_q[wr_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q        <= wr_ptr_q + LOG2'(1);
      if (!full) fill_q <= fill_q + (LOG2 + 1)'(1);
    end
  end

endmodule

// File: rtl/pulse_stats_collector.sv
// Collects pulse widths on done_tick edges: sliding-window average, min/max and sample count.
module pulse_stats_collector
  import pulse_meas_pkg::*;
#(
  parameter int unsigned W_TIME = W_TIME_DEF,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_tick,
  input  logic [W_TIME-1:0] time_ms,
  input  logic              clear,
  output logic              update_tick,
  output logic              stats_valid,
  output logic [W_TIME-1:0] avg_ms,
  output logic [W_TIME-1:0] min_ms,
  output logic [W_TIME-1:0] max_ms,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              overrun
);
  localparam int unsigned LOG2  = $clog2(DEPTH);
  localparam int unsigned SUM_W = W_TIME + LOG2;

  stats_state_t      state_q, state_d;
  logic              done_tick_q;
  logic              pending_q, pending_d;
  logic              src_hold_q, src_hold_d;
  logic [W_TIME-1:0] sample_q, hold_q, new_data, old_data;
  logic [W_TIME-1:0] min_q, max_q, avg_q, avg_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q, overrun_q, full;
  logic              accept, busy, take, drop, cap, do_update;

  assign accept    = done_tick & ~done_tick_q & ~clear;
  assign busy      = (state_q != S_IDLE) | pending_q;
  assign cap       = accept & ~busy;
  assign take      = accept & busy & ~pending_q;
  assign drop      = accept & busy & pending_q;
  assign do_update = (state_q == S_UPDATE) & ~clear;
  assign new_data  = src_hold_q ? hold_q : sample_q;
  assign sum_d     = sum_q + SUM_W'(new_data) - SUM_W'(old_data);
  assign avg_d     = full ? W_TIME'(sum_q >> LOG2) : '0;

  pulse_stats_ring #(
    .W_TIME (W_TIME),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear),
    .wr_en    (do_update),
    .wr_data  (new_data),
    .old_data (old_data),
    .full     (full)
  );

  // The holding register stays occupied until its own sample has published.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    src_hold_d = src_hold_q;
    if (take) pending_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (cap) begin
          state_d    = S_UPDATE;
          src_hold_d = 1'b0;
        end else if (pending_q) begin
          state_d    = S_UPDATE;
          src_hold_d = 1'b1;
        end
      end
      S_UPDATE: state_d = S_PUBLISH;
      S_PUBLISH: begin
        if (src_hold_q) pending_d = 1'b0;
        if (pending_d) begin
          state_d    = S_UPDATE;
          src_hold_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New avg/valid are forwarded during the publish cycle so they appear with update_tick.
  assign update_tick = (state_q == S_PUBLISH) & ~clear;
  assign avg_ms      = update_tick ? avg_d : avg_q;
  assign stats_valid = update_tick ? full : valid_q;
  assign min_ms      = min_q;
  assign max_ms      = max_q;
  assign sample_cnt  = cnt_q;
  assign overrun     = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_tick_q <= 1'b0;
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      src_hold_q  <= 1'b0;
      sample_q    <= '0;
      hold_q      <= '0;
      sum_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      avg_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_tick_q <= done_tick;
      if (clear) begin
        state_q    <= S_IDLE;
        pending_q  <= 1'b0;
        src_hold_q <= 1'b0;
        sample_q   <= '0;
        hold_q     <= '0;
        sum_q      <= '0;
        min_q      <= '1;
        max_q      <= '0;
        avg_q      <= '0;
        cnt_q      <= '0;
        valid_q    <= 1'b0;
        overrun_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        pending_q  <= pending_d;
        src_hold_q <= src_hold_d;
        if (cap)  sample_q  <= time_ms;
        if (take) hold_q    <= time_ms;
        if (drop) overrun_q <= 1'b1;
        if (state_q == S_UPDATE) begin
          sum_q <= sum_d;
          if (new_data < min_q) min_q <= new_data;
          if (new_data > max_q) max_q <= new_data;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        if (state_q == S_PUBLISH) begin
          avg_q   <= avg_d;
          valid_q <= full;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_stats_collector.sv
// Directed bench for pulse_stats_collector with a 4-deep window.
module tb_pulse_stats_collector;
  localparam int unsigned W_TIME = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done_tick = 1'b0;
  logic              clear = 1'b0;
  logic [W_TIME-1:0] time_ms = '0;
  logic              update_tick, stats_valid, overrun;
  logic [W_TIME-1:0] avg_ms, min_ms, max_ms;
  logic [CNT_W-1:0]  sample_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_cyc[$];
  int tick_avg[$];

  pulse_stats_collector #(
    .W_TIME (W_TIME),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done_tick   (done_tick),
    .time_ms     (time_ms),
    .clear       (clear),
    .update_tick (update_tick),
    .stats_valid (stats_valid),
    .avg_ms      (avg_ms),
    .min_ms      (min_ms),
    .max_ms      (max_ms),
    .sample_cnt  (sample_cnt),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (update_tick === 1'b1) begin
      tick_cyc.push_back(cyc);
      tick_avg.push_back(int'(avg_ms));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle done_tick pulse; t is the accept cycle.
  task automatic send(input logic [W_TIME-1:0] v, input int gap, output int t);
    @(posedge clk); #1;
    time_ms = v; done_tick = 1'b1; t = cyc;
    @(posedge clk); #1;
    done_tick = 1'b0;
    idle(gap);
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (avg_ms !== 32'd0) begin errors++; $display("FAIL reset_avg: got %0d want 0", avg_ms); end
    checks++; if (min_ms !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_min: got %h want ffffffff", min_ms); end
    checks++; if (max_ms !== 32'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max_ms); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sample_cnt); end
    checks++; if ({stats_valid, overrun, update_tick} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {stats_valid, overrun, update_tick});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_window();
    int vals [4] = '{100, 200, 50, 150};
    int e_avg[4] = '{0, 0, 0, 125};
    int e_min[4] = '{100, 100, 50, 50};
    int e_max[4] = '{100, 200, 200, 200};
    int t, first;
    for (int i = 0; i < 4; i++) begin
      tick_cyc.delete(); tick_avg.delete();
      send(vals[i], 18, t);
      first = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
      checks++; if (tick_cyc.size() != 1 || first != t + 2) begin
        errors++; $display("FAIL win_tick%0d: got n=%0d at %0d want n=1 at %0d", i, tick_cyc.size(), first, t + 2);
      end
      checks++; if (avg_ms !== W_TIME'(e_avg[i])) begin errors++; $display("FAIL win_avg%0d: got %0d want %0d", i, avg_ms, e_avg[i]); end
      checks++; if (stats_valid !== (i == 3)) begin errors++; $display("FAIL win_valid%0d: got %b want %b", i, stats_valid, i == 3); end
      checks++; if (min_ms !== W_TIME'(e_min[i])) begin errors++; $display("FAIL win_min%0d: got %0d want %0d", i, min_ms, e_min[i]); end
      checks++; if (max_ms !== W_TIME'(e_max[i])) begin errors++; $display("FAIL win_max%0d: got %0d want %0d", i, max_ms, e_max[i]); end
      checks++; if (sample_cnt !== CNT_W'(i + 1)) begin errors++; $display("FAIL win_cnt%0d: got %0d want %0d", i, sample_cnt, i + 1); end
    end
    checks++; if (tick_avg.size() != 1 || tick_avg[0] != 125) begin
      errors++; $display("FAIL win_avg_at_tick: got n=%0d want avg 125 with the tick", tick_avg.size());
    end
  endtask

  task automatic test_slide();
    int t, first;
    tick_cyc.delete(); tick_avg.delete();
    send(250, 10, t);
    first = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
    checks++; if (tick_cyc.size() != 1 || first != t + 2) begin
      errors++; $display("FAIL slide_tick: got n=%0d at %0d want n=1 at %0d", tick_cyc.size(), first, t + 2);
    end
    checks++; if (avg_ms !== 32'd162) begin errors++; $display("FAIL slide_avg: got %0d want 162", avg_ms); end
    checks++; if (min_ms !== 32'd50) begin errors++; $display("FAIL slide_min: got %0d want 50", min_ms); end
    checks++; if (max_ms !== 32'd250) begin errors++; $display("FAIL slide_max: got %0d want 250", max_ms); end
    checks++; if (sample_cnt !== 16'd5) begin errors++; $display("FAIL slide_cnt: got %0d want 5", sample_cnt); end
  endtask

  task automatic test_held();
    int t, first;
    tick_cyc.delete(); tick_avg.delete();
    @(posedge clk); #1;
    time_ms = 77; done_tick = 1'b1; t = cyc;
    idle(6);
    done_tick = 1'b0;
    idle(8);
    first = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
    checks++; if (tick_cyc.size() != 1 || first != t + 2) begin
      errors++; $display("FAIL held_tick: got n=%0d at %0d want n=1 at %0d", tick_cyc.size(), first, t + 2);
    end
    checks++; if (sample_cnt !== 16'd6) begin errors++; $display("FAIL held_cnt: got %0d want 6", sample_cnt); end
    checks++; if (avg_ms !== 32'd131) begin errors++; $display("FAIL held_avg: got %0d want 131", avg_ms); end
  endtask

  task automatic test_back_to_back();
    int t, n;
    int c0, c1;
    tick_cyc.delete(); tick_avg.delete();
    @(posedge clk); #1; time_ms = 10; done_tick = 1'b1; t = cyc;
    @(posedge clk); #1; done_tick = 1'b0;
    @(posedge clk); #1; time_ms = 20; done_tick = 1'b1;
    @(posedge clk); #1; done_tick = 1'b0;
    @(posedge clk); #1; time_ms = 30; done_tick = 1'b1;
    @(posedge clk); #1; done_tick = 1'b0;
    idle(8);
    n  = tick_cyc.size();
    c0 = (n > 0) ? tick_cyc[0] : -1;
    c1 = (n > 1) ? tick_cyc[1] : -1;
    checks++; if (n != 2 || c0 != t + 2 || c1 != t + 4) begin
      errors++; $display("FAIL b2b_ticks: got n=%0d at %0d,%0d want 2 at %0d,%0d", n, c0, c1, t + 2, t + 4);
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    checks++; if (sample_cnt !== 16'd8) begin errors++; $display("FAIL b2b_cnt: got %0d want 8", sample_cnt); end
    checks++; if (min_ms !== 32'd10) begin errors++; $display("FAIL b2b_min: got %0d want 10", min_ms); end
    checks++; if (avg_ms !== 32'd89) begin errors++; $display("FAIL b2b_avg: got %0d want 89", avg_ms); end
  endtask

  task automatic test_clear();
    tick_cyc.delete(); tick_avg.delete();
    @(posedge clk); #1; clear = 1'b1; done_tick = 1'b1; time_ms = 5;
    @(posedge clk); #1; clear = 1'b0; done_tick = 1'b0;
    idle(6);
    checks++; if (tick_cyc.size() != 0) begin errors++; $display("FAIL clr_tick: got %0d ticks want 0", tick_cyc.size()); end
    checks++; if (avg_ms !== 32'd0 || max_ms !== 32'd0) begin
      errors++; $display("FAIL clr_avg_max: got %0d/%0d want 0/0", avg_ms, max_ms);
    end
    checks++; if (min_ms !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clr_min: got %h want ffffffff", min_ms); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", sample_cnt); end
    checks++; if ({stats_valid, overrun} !== 2'b00) begin
      errors++; $display("FAIL clr_flags: got %b want 00", {stats_valid, overrun});
    end
  endtask

  task automatic test_async_reset();
    int t;
    send(60, 6, t);
    checks++; if (sample_cnt !== 16'd1 || min_ms !== 32'd60) begin
      errors++; $display("FAIL ar_pre: got cnt %0d min %0d want 1/60", sample_cnt, min_ms);
    end
    @(posedge clk); #1; time_ms = 70; done_tick = 1'b1;
    @(posedge clk); #1; done_tick = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (sample_cnt !== 16'd0 || max_ms !== 32'd0 || min_ms !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL ar_async: got cnt %0d min %h max %0d want 0/ffffffff/0", sample_cnt, min_ms, max_ms);
    end
    checks++; if ({update_tick, stats_valid, overrun} !== 3'b000 || avg_ms !== 32'd0) begin
      errors++; $display("FAIL ar_flags: got %b avg %0d want 000 avg 0", {update_tick, stats_valid, overrun}, avg_ms);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    tick_cyc.delete(); tick_avg.delete();
    send(40, 6, t);
    checks++; if (min_ms !== 32'd40 || max_ms !== 32'd40) begin
      errors++; $display("FAIL ar_minmax: got %0d/%0d want 40/40", min_ms, max_ms);
    end
    checks++; if (sample_cnt !== 16'd1 || tick_cyc.size() != 1) begin
      errors++; $display("FAIL ar_cnt: got cnt %0d ticks %0d want 1/1", sample_cnt, tick_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_slide();
    test_held();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
